// File: rtl/muladd_pkg.sv
// Shared widths, result-width helper and stage-1 payload layout for the multiply-add pipeline.
// Optional range check in muladd_p2 is enabled by defining MULADD_RANGE_CHK_EN.
package muladd_pkg;
    localparam int K_DEF = 32;

    function automatic int XW(input int k);
        return 2 * k;
    endfunction

    // Stage-1 payload at the default operand width.
    typedef struct packed {
        logic [K_DEF + K_DEF/2 - 1:0] pl;
        logic [K_DEF + K_DEF/2 - 1:0] ph;
        logic [K_DEF - 1:0]           r1;
        logic                         chk1;
    } stage1_t;
endpackage

// File: rtl/muladd_p2_if.sv
// Operand/result handshake bundle for muladd_p2; slave side is the pipeline, master the producer/consumer.
interface muladd_p2_if
    import muladd_pkg::*;
#(
    parameter int K = K_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [K-1:0]     q;
    logic [K-1:0]     d;
    logic [K-1:0]     r;
    logic             out_valid;
    logic             out_ready;
    logic [XW(K)-1:0] x;
    logic             err;

    modport master (
        output in_valid, q, d, r, out_ready,
        input  in_ready, out_valid, x, err
    );

    modport slave (
        input  in_valid, q, d, r, out_ready,
        output in_ready, out_valid, x, err
    );
endinterface

// File: rtl/muladd_pp.sv
// Combinational K x HK unsigned partial-product multiplier.
// Zero latency; no handshake.
module muladd_pp #(
    parameter int K  = 32,
    parameter int HK = 16
) (
    input  logic [HK-1:0]   a,
    input  logic [K-1:0]    b,
    output logic [K+HK-1:0] p
);
    localparam int PW = K + HK;

    assign p = PW'(a) * PW'(b);
endmodule

// File: rtl/muladd_p2.sv
// Two-stage pipelined x = q*d + r (unsigned, 2*K-bit result); 2-cycle latency.
// Bubble-collapsing valid/ready: a stage loads when it is empty or its successor advances.
// MULADD_RANGE_CHK_EN: err flags a non-canonical remainder; otherwise err is constant 0.
module muladd_p2
    import muladd_pkg::*;
#(
    parameter int K = K_DEF
) (
    input  logic       clk,
    input  logic       rst,
    muladd_p2_if.slave bus
);
    localparam int HK = K / 2;
    localparam int PW = K + HK;
    localparam int W  = XW(K);

    typedef struct packed {
        logic [PW-1:0] pl;
        logic [PW-1:0] ph;
        logic [K-1:0]  r1;
        logic          chk1;
    } s1_t;

    logic [PW-1:0] pl_c;
    logic [PW-1:0] ph_c;
    logic          chk_c;
    logic          v1;
    logic          v2;
    logic          adv1;
    logic          adv2;
    s1_t           s1;
    logic [W-1:0]  x_nxt;
    logic [W-1:0]  x_q;
    logic          err_q;

    muladd_pp #(.K(K), .HK(HK)) u_pp_lo (
        .a (bus.q[HK-1:0]),
        .b (bus.d),
        .p (pl_c)
    );

    muladd_pp #(.K(K), .HK(HK)) u_pp_hi (
        .a (bus.q[K-1:HK]),
        .b (bus.d),
        .p (ph_c)
    );

`ifdef MULADD_RANGE_CHK_EN
    // A divide-by-zero result is only canonical when the divider returned all-ones.
    always_comb begin
        chk_c = 1'b0;
        if (bus.d != '0) chk_c = (bus.r >= bus.d);
        else             chk_c = (bus.q != '1);
    end
`else
    assign chk_c = 1'b0;
`endif

    assign adv2         = ~v2 | bus.out_ready;
    assign adv1         = ~v1 | adv2;
    assign bus.in_ready = adv1;

    always_comb begin
        x_nxt = (W'(s1.ph) << HK) + W'(s1.pl) + W'(s1.r1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            x_q   <= '0;
            err_q <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    s1.pl   <= pl_c;
                    s1.ph   <= ph_c;
                    s1.r1   <= bus.r;
                    s1.chk1 <= chk_c;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    x_q   <= x_nxt;
                    err_q <= s1.chk1;
                end
            end
        end
    end

    assign bus.out_valid = v2;
    assign bus.x         = x_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_muladd_p2.sv
// Randomized bench for muladd_p2 against a plain-arithmetic model of q*d + r and a divider round trip.
module tb_muladd_p2;
    import muladd_pkg::*;

    localparam int K = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muladd_p2_if #(.K(K)) bus ();
    muladd_p2 #(.K(K)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          acc;
    bit          emt;
    logic [63:0] xs;
    logic        es;

    function automatic logic [63:0] ref_x(input logic [31:0] q, input logic [31:0] d, input logic [31:0] r);
        return 64'(q) * 64'(d) + 64'(r);
    endfunction

    function automatic logic ref_err(input logic [31:0] q, input logic [31:0] d, input logic [31:0] r);
`ifdef MULADD_RANGE_CHK_EN
        if (d == 32'd0) return q != 32'hFFFF_FFFF;
        return r >= d;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: records handshakes and outputs at the negedge, returns 1 time unit after posedge.
    task automatic cycle();
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        emt = bus.out_valid && bus.out_ready;
        xs  = bus.x;
        es  = bus.err;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] q, input logic [31:0] d, input logic [31:0] r);
        bus.in_valid = v;
        bus.q = q;
        bus.d = d;
        bus.r = r;
    endtask

    task automatic send_one(input logic [31:0] q, input logic [31:0] d, input logic [31:0] r,
                            output logic [63:0] xo, output logic eo, output bit ok);
        ok = 0;
        xo = '0;
        eo = 1'b0;
        drive(1, q, d, r);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            cycle();
            if (acc) ok = 1;
        end
        bus.in_valid = 1'b0;
        if (!ok) return;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) begin
                ok = 1;
                break;
            end
            cycle();
        end
        xo = bus.x;
        eo = bus.err;
        if (ok) cycle();
    endtask

    task automatic gen_div(output logic [31:0] q, output logic [31:0] d, output logic [31:0] r,
                           output logic [63:0] dividend);
        logic [31:0] th;
        logic [31:0] tl;
        d = $urandom;
        if ($urandom_range(3) == 0) d = $urandom_range(255);
        if (d == 32'd0) d = 32'd1;
        th = $urandom % d;
        tl = $urandom;
        dividend = {th, tl};
        q = 32'(dividend / 64'(d));
        r = 32'(dividend % 64'(d));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, $urandom, $urandom, $urandom);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b need 0", bus.out_valid); end
            n_cmp++; if (bus.x !== 64'd0) begin n_fail++; $display("FAIL reset_x: got %0h need 0", bus.x); end
            n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b need 0", bus.err); end
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b need 0", bus.out_valid); end
    endtask

    task automatic test_basic();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b need 1", bus.in_ready); end
        drive(1, 32'd3, 32'd7, 32'd5);
        bus.out_ready = 1'b1;
        cycle();
        n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b need 1", acc); end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b need 0", bus.out_valid); end
        cycle();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b need 1", bus.out_valid); end
        n_cmp++; if (bus.x !== 64'd26) begin n_fail++; $display("FAIL basic_x: got %0d need 26", bus.x); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b need 0", bus.err); end
        cycle();
    endtask

    task automatic test_max();
        logic [63:0] xo;
        logic        eo;
        bit          ok;
        send_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, xo, eo, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL max_timeout: got %b need 1", ok); end
        n_cmp++; if (xo !== 64'hFFFF_FFFF_0000_0000) begin n_fail++; $display("FAIL max_x: got %0h need ffffffff00000000", xo); end
        n_cmp++; if (eo !== ref_err(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF)) begin n_fail++; $display("FAIL max_err: got %b", eo); end
    endtask

    task automatic test_range();
        logic [31:0] tq [6] = '{32'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd9, 32'd5};
        logic [31:0] td [6] = '{32'd4, 32'd0, 32'd0, 32'd0, 32'd10, 32'd3};
        logic [31:0] tr [6] = '{32'd4, 32'd9, 32'd5, 32'd7, 32'd9, 32'd2};
        logic [63:0] xo;
        logic        eo;
        bit          ok;
        for (int i = 0; i < 6; i++) begin
            send_one(tq[i], td[i], tr[i], xo, eo, ok);
            n_cmp++; if (ok !== 1'b1 || xo !== ref_x(tq[i], td[i], tr[i])) begin
                n_fail++; $display("FAIL range_x[%0d]: got %0h need %0h", i, xo, ref_x(tq[i], td[i], tr[i]));
            end
            n_cmp++; if (eo !== ref_err(tq[i], td[i], tr[i])) begin
                n_fail++; $display("FAIL range_err[%0d]: got %b need %b", i, eo, ref_err(tq[i], td[i], tr[i]));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] iq [4];
        logic [31:0] id [4];
        logic [31:0] ir [4];
        logic [63:0] exp_q [$];
        logic [63:0] want;
        int          idx = 0;
        int          got = 0;
        for (int i = 0; i < 4; i++) begin
            iq[i] = $urandom; id[i] = $urandom; ir[i] = $urandom;
        end
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(idx < 4, iq[idx % 4], id[idx % 4], ir[idx % 4]);
            cycle();
            if (acc) begin exp_q.push_back(ref_x(iq[idx], id[idx], ir[idx])); idx++; end
            if (c >= 1) begin
                n_cmp++; if (bus.out_valid !== 1'b1 || bus.x !== ref_x(iq[0], id[0], ir[0])) begin
                    n_fail++; $display("FAIL stall_hold[%0d]: valid %b x %0h need %0h", c, bus.out_valid, bus.x, ref_x(iq[0], id[0], ir[0]));
                end
            end
        end
        n_cmp++; if (idx !== 2) begin n_fail++; $display("FAIL stall_accepts: got %0d need 2", idx); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b need 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            drive(idx < 4, iq[idx % 4], id[idx % 4], ir[idx % 4]);
            cycle();
            if (acc) begin exp_q.push_back(ref_x(iq[idx], id[idx], ir[idx])); idx++; end
            if (emt) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
                n_cmp++; if (xs !== want) begin n_fail++; $display("FAIL stall_order[%0d]: got %0h need %0h", got, xs, want); end
                got++;
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (got !== 4) begin n_fail++; $display("FAIL stall_count: got %0d need 4", got); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] cq;
        logic [31:0] cd;
        logic [31:0] cr;
        logic [63:0] exp_q [$];
        logic [63:0] want;
        int          sent = 0;
        int          got = 0;
        int          last_emit = -1;
        bus.out_ready = 1'b1;
        cq = $urandom; cd = $urandom; cr = $urandom;
        for (int c = 0; c < 20 && got < 8; c++) begin
            drive(sent < 8, cq, cd, cr);
            cycle();
            if (sent < 8) begin
                n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept[%0d]: got %b need 1", c, acc); end
            end
            if (acc) begin exp_q.push_back(ref_x(cq, cd, cr)); sent++; cq = $urandom; cd = $urandom; cr = $urandom; end
            if (emt) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
                n_cmp++; if (xs !== want) begin n_fail++; $display("FAIL b2b_x[%0d]: got %0h need %0h", got, xs, want); end
                if (last_emit >= 0) begin
                    n_cmp++; if (c - last_emit !== 1) begin n_fail++; $display("FAIL b2b_gap: got %0d need 1", c - last_emit); end
                end
                last_emit = c;
                got++;
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (got !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d need 8", got); end
    endtask

    task automatic test_round_trip();
        localparam int N = 10000;
        logic [31:0] cq;
        logic [31:0] cd;
        logic [31:0] cr;
        logic [63:0] cdiv;
        logic [63:0] exp_q [$];
        logic [63:0] want;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        int          bad = 0;
        gen_div(cq, cd, cr, cdiv);
        while (got < N && cyc < 60000) begin
            drive((sent < N) && ($urandom_range(3) != 0), cq, cd, cr);
            bus.out_ready = ($urandom_range(3) != 0);
            cycle();
            cyc++;
            if (acc) begin exp_q.push_back(cdiv); sent++; gen_div(cq, cd, cr, cdiv); end
            if (emt) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
                n_cmp++; if (xs !== want || es !== 1'b0) begin
                    n_fail++; bad++;
                    if (bad <= 5) $display("FAIL rt_x[%0d]: got %0h err %b need %0h err 0", got, xs, es, want);
                end
                got++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++; if (got !== N) begin n_fail++; $display("FAIL rt_count: got %0d need %0d", got, N); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] nq;
        logic [31:0] nd;
        logic [31:0] nr;
        logic [63:0] xo;
        logic        eo;
        bit          ok;
        bus.out_ready = 1'b0;
        drive(1, $urandom, $urandom, $urandom);
        cycle();
        drive(1, $urandom, $urandom, $urandom);
        cycle();
        rst = 1'b1;
        drive(1, $urandom, $urandom, $urandom);
        bus.out_ready = 1'b1;
        cycle();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mreset_valid: got %b need 0", bus.out_valid); end
        n_cmp++; if (bus.x !== 64'd0) begin n_fail++; $display("FAIL mreset_x: got %0h need 0", bus.x); end
        nq = $urandom; nd = $urandom; nr = $urandom;
        send_one(nq, nd, nr, xo, eo, ok);
        n_cmp++; if (ok !== 1'b1 || xo !== ref_x(nq, nd, nr)) begin
            n_fail++; $display("FAIL mreset_next: got %0h need %0h", xo, ref_x(nq, nd, nr));
        end
        n_cmp++; if (eo !== ref_err(nq, nd, nr)) begin n_fail++; $display("FAIL mreset_err: got %b need %b", eo, ref_err(nq, nd, nr)); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.q         = '0;
        bus.d         = '0;
        bus.r         = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_basic();
        test_max();
        test_range();
        test_stall();
        test_back_to_back();
        test_round_trip();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
